div8_seq: RTL and testbench

Sequential 8-bit unsigned restoring divider that drives the team's 8-bit ripple-borrow subtractor `ebsUfs` once per iteration and consumes its difference and borrow-out. It sits directly downstream of the subtractor. The block:

- takes a dividend/divisor pair on a `start` strobe;
- runs one shift-subtract step per clock;
- returns quotient and remainder with a one-cycle `done` pulse.

It is the first multi-cycle arithmetic unit in the arithmetic library. It reuses the combinational subtractor instead of duplicating it.

---
 rtl/div8_pkg.sv | 19 +
 rtl/ebsUfs.sv | 20 ++
 rtl/div8_seq.sv | 118 +++++++++++
 tb/tb_div8_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/div8_pkg.sv
// Shared constants for the sequential 8-bit divider: FSM encodings, iteration count,
// divide-by-zero quotient and the registered result bundle.
package div8_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int unsigned ITERS = 8;

   localparam logic [7:0] DBZ_QUOTIENT = 8'hFF;

   typedef struct packed {
      logic [7:0] quotient;
      logic [7:0] remainder;
      logic       div_by_zero;
   } div_result_t;

endpackage

// File: rtl/ebsUfs.sv
// 8-bit ripple-borrow subtractor: diff = a - b, borrow_out = 1 when a < b.
module ebsUfs (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] diff,
   output logic       borrow_out
);

   always_comb begin
      logic bw;
      bw   = 1'b0;
      diff = '0;
      for (int i = 0; i < 8; i++) begin
         diff[i] = a[i] ^ b[i] ^ bw;
         bw      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
      end
      borrow_out = bw;
   end

endmodule

// File: rtl/div8_seq.sv
// Sequential 8-bit unsigned restoring divider: one shift-subtract step per clock through
// the shared ebsUfs subtractor, results registered with a one-cycle done pulse.
module div8_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ITERS = div8_pkg::ITERS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   import div8_pkg::*;

   if (WIDTH != 8 || ITERS != WIDTH) begin : g_bad_width
      $error("div8_seq: WIDTH and ITERS must both be 8 to match the ebsUfs subtractor");
   end

   logic [1:0]  state_q, state_d;
   logic [7:0]  r_q, r_d;
   logic [7:0]  q_q, q_d;
   logic [7:0]  d_q, d_d;
   logic [2:0]  cnt_q, cnt_d;
   div_result_t res_q, res_d;

   logic [7:0] shifted;
   logic [7:0] sub_diff;
   logic       sub_borrow;
   logic [7:0] r_step;
   logic [7:0] q_step;

   // R stays <= 127 before each shift, so the shifted remainder always fits in 8 bits.
   assign shifted = {r_q[6:0], q_q[7]};

   ebsUfs u_sub (
      .a          (shifted),
      .b          (d_q),
      .diff       (sub_diff),
      .borrow_out (sub_borrow)
   );

   assign r_step = sub_borrow ? shifted : sub_diff;
   assign q_step = {q_q[6:0], ~sub_borrow};

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      res_d   = res_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               q_d   = dividend;
               d_d   = divisor;
               r_d   = '0;
               cnt_d = '0;
               if (divisor == '0) begin
                  // No iterations: publish the saturated result right away.
                  state_d           = DONE;
                  res_d.quotient    = DBZ_QUOTIENT;
                  res_d.remainder   = dividend;
                  res_d.div_by_zero = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            r_d   = r_step;
            q_d   = q_step;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(ITERS - 1)) begin
               state_d           = DONE;
               res_d.quotient    = q_step;
               res_d.remainder   = r_step;
               res_d.div_by_zero = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign quotient    = res_q.quotient;
   assign remainder   = res_q.remainder;
   assign div_by_zero = res_q.div_by_zero;

endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: directed vector table, multi-cycle corner sequences
// and random operands checked against an arithmetic reference model.
module tb_div8_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int checks = 0;
   int errors = 0;

   div8_seq dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] dvd;
      logic [7:0] dvs;
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
      int         lat;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Reference: plain arithmetic, saturated quotient on a zero divisor.
   task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r, output logic z);
      if (b == 8'd0) begin
         q = 8'hFF;
         r = a;
         z = 1'b1;
      end else begin
         q = a / b;
         r = a % b;
         z = 1'b0;
      end
   endtask

   // Ticks until done is seen (or a 30-cycle budget expires); lat counts cycles after start.
   task automatic wait_done(input int lat0, input bit hold, output int lat, output int bcnt);
      bit seen;
      lat  = lat0;
      bcnt = 0;
      seen = 1'b0;
      while (!seen && lat < 30) begin
         tick();
         lat++;
         if (!hold) start = 1'b0;
         if (done) seen = 1'b1;
         else if (busy) bcnt++;
      end
   endtask

   task automatic run_one(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez,
                          input int elat);
      int lat;
      int bcnt;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      wait_done(0, 1'b0, lat, bcnt);
      check({name, " latency"}, lat, elat);
      check({name, " busy cycles"}, bcnt, ez ? 0 : 8);
      check({name, " quotient"}, quotient, eq);
      check({name, " remainder"}, remainder, er);
      check({name, " div_by_zero"}, div_by_zero, ez);
      tick();
      check({name, " done pulse width"}, done, 0);
      check({name, " quotient hold"}, quotient, eq);
   endtask

   initial begin
      int lat;
      int bcnt;
      int dcnt;
      logic [7:0] a, b, eq, er;
      logic ez;

      vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 9};
      vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9};
      vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 9};
      vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9};
      vecs[4] = '{8'd13,  8'd0,   8'hFF,  8'd13, 1'b1, 1};
      vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 9};
      vecs[6] = '{8'd128, 8'd16,  8'd8,   8'd0,  1'b0, 9};
      vecs[7] = '{8'd0,   8'd0,   8'hFF,  8'd0,  1'b1, 1};

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) tick();
      rst = 1'b0;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset quotient", quotient, 0);
      check("reset remainder", remainder, 0);
      check("reset div_by_zero", div_by_zero, 0);
      tick();

      for (int i = 0; i < 8; i++) begin
         run_one($sformatf("vec%0d %0d/%0d", i, vecs[i].dvd, vecs[i].dvs), vecs[i].dvd,
                 vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat);
      end

      // A start pulse mid-RUN must be ignored.
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd3;
      tick();
      start = 1'b0;
      tick();
      tick();
      start    = 1'b1;
      dividend = 8'd50;
      divisor  = 8'd5;
      tick();
      start = 1'b0;
      wait_done(4, 1'b0, lat, bcnt);
      check("ignore latency", lat, 9);
      check("ignore quotient", quotient, 33);
      check("ignore remainder", remainder, 1);
      tick();
      check("ignore no restart", busy, 0);

      // Reset mid-RUN discards the operation.
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd3;
      tick();
      start = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst busy", busy, 0);
      check("midrst done", done, 0);
      check("midrst quotient", quotient, 0);
      check("midrst remainder", remainder, 0);
      check("midrst div_by_zero", div_by_zero, 0);
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) dcnt++;
      end
      check("midrst no done", dcnt, 0);
      run_one("after reset 100/3", 8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 9);

      // start held high across done: back-to-back divisions, no idle gap.
      start    = 1'b1;
      dividend = 8'd200;
      divisor  = 8'd7;
      wait_done(0, 1'b1, lat, bcnt);
      check("b2b first latency", lat, 9);
      check("b2b first quotient", quotient, 28);
      check("b2b first remainder", remainder, 4);
      dividend = 8'd9;
      divisor  = 8'd2;
      wait_done(0, 1'b1, lat, bcnt);
      start = 1'b0;
      check("b2b gap", lat, 9);
      check("b2b second quotient", quotient, 4);
      check("b2b second remainder", remainder, 1);
      tick();
      check("b2b done drops", done, 0);
      tick();

      for (int i = 0; i < 150; i++) begin
         a = 8'($urandom);
         b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
         ref_div(a, b, eq, er, ez);
         run_one($sformatf("rand%0d %0d/%0d", i, a, b), a, b, eq, er, ez, ez ? 1 : 9);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
